// File: rtl/xbar_slave_ram.sv
// xbar_slave_ram: single-port word-addressed RAM endpoint for one crossbar slave port.
// Accepts one request at a time, inserts WAIT_CYCLES wait states, then returns a
// one-cycle ack pulse followed by a mandatory ack-low HOLD cycle. rdata is registered
// and holds its value until the next read completes.
// Optional feature: define XBAR_SLAVE_RAM_RANGE_CHECK_EN to reject addresses with any of
// addr[30:ADDR_W+2] set. Such writes are dropped and such reads return 32'hDEAD_BEEF.
module xbar_slave_ram #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        req,
  input  logic        cmd,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StWait, StAck, StHold} state_e;

  state_e            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_cmd;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic              r_ack;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem [Depth];

  logic              w_idle;
  logic              w_capture;
  logic              w_enter_ack;
  logic              w_wr_en;
  logic              w_op_cmd;
  logic              w_op_oor;
  logic [ADDR_W-1:0] w_op_idx;
  logic [31:0]       w_op_wdata;
  // addr[31] and addr[1:0] are never decoded here; the upper word bits only with range check.
  logic [31:0]       w_unused_addr;

  assign w_unused_addr = addr;
  assign w_idle        = (r_state == StIdle);
  assign w_capture     = w_idle && req;

  // With zero wait states ACK is entered on the capture edge, so the live inputs are used.
  assign w_op_cmd   = w_idle ? cmd                : r_cmd;
  assign w_op_idx   = w_idle ? addr[ADDR_W+1:2]   : r_idx;
  assign w_op_wdata = w_idle ? wdata              : r_wdata;

`ifdef XBAR_SLAVE_RAM_RANGE_CHECK_EN
  logic w_in_oor;
  logic r_oor;

  assign w_in_oor = |(addr[30:0] >> (ADDR_W + 2));
  assign w_op_oor = w_idle ? w_in_oor : r_oor;

  // Latch the out-of-range flag alongside the request fields.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_oor <= 1'b0;
    end else if (w_capture) begin
      r_oor <= w_in_oor;
    end
  end
`else
  assign w_op_oor = 1'b0;
`endif

  // Write only on the ACK entry edge; a reset in progress must not commit a write.
  assign w_wr_en = PRESETN && w_enter_ack && w_op_cmd && !w_op_oor;

  // Next-state logic: wait-state countdown, abort on req drop, fixed ACK/HOLD tail.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_enter_ack = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req) begin
          w_cnt_nxt = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = StAck;
            w_enter_ack = 1'b1;
          end else begin
            w_state_nxt = StWait;
          end
        end
      end
      StWait: begin
        if (!req) begin
          w_state_nxt = StIdle;
        end else if (r_cnt == 4'd1) begin
          w_state_nxt = StAck;
          w_enter_ack = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      StAck:   w_state_nxt = StHold;
      StHold:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request fields are sampled only when a request is accepted in IDLE.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_cmd   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
    end else if (w_capture) begin
      r_cmd   <= cmd;
      r_idx   <= addr[ADDR_W+1:2];
      r_wdata <= wdata;
    end
  end

  // Completion pulse and read data, both updated on the edge that enters ACK.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ack <= w_enter_ack;
      if (w_enter_ack && !w_op_cmd) begin
        r_rdata <= w_op_oor ? 32'hDEAD_BEEF : r_mem[w_op_idx];
      end
    end
  end

  // Storage array; deliberately not reset so contents survive PRESETN.
  always_ff @(posedge PCLK) begin
    if (w_wr_en) begin
      r_mem[w_op_idx] <= w_op_wdata;
    end
  end

  assign ack   = r_ack;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_xbar_slave_ram.sv
// Bench for xbar_slave_ram: directed table, hand-written multi-cycle corner cases, and
// randomized traffic checked against a word-array reference model.
module tb_xbar_slave_ram;

  localparam int unsigned AddrW      = 8;
  localparam int unsigned WaitCycles = 2;

  logic        PCLK;
  logic        PRESETN;
  logic        req, cmd;
  logic [31:0] addr, wdata, rdata;
  logic        ack;
  logic        req0, cmd0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ack0;

  int n_vec;
  int n_err;

  xbar_slave_ram #(.ADDR_W(AddrW), .WAIT_CYCLES(WaitCycles)) u_dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata)
  );

  xbar_slave_ram #(.ADDR_W(AddrW), .WAIT_CYCLES(0)) u_dut0 (
    .PCLK(PCLK), .PRESETN(PRESETN), .req(req0), .cmd(cmd0), .addr(addr0), .wdata(wdata0),
    .ack(ack0), .rdata(rdata0)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Reference model: plain word array plus the last value a read returned.
  logic [31:0] m_mem [256];
  logic [31:0] m_rdata;
  int          wq[$];

  function automatic bit is_oor(input logic [31:0] a);
`ifdef XBAR_SLAVE_RAM_RANGE_CHECK_EN
    return (a[30:10] != 21'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction on the WAIT_CYCLES instance; starts and ends with DUT in IDLE.
  task automatic txn(input logic c, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] got);
    int          lat;
    logic [31:0] exp;
    int          idx;
    bit          oor;
    idx = int'(a[9:2]);
    oor = is_oor(a);
    if (c) exp = m_rdata;
    else   exp = oor ? 32'hDEAD_BEEF : m_mem[idx];
    req = 1'b1; cmd = c; addr = a; wdata = d;
    lat = 0;
    do begin
      @(negedge PCLK);
      lat++;
      if (!ack) begin
        // Fields are only sampled in IDLE, so scrambling them here must be harmless.
        cmd = 1'($urandom); addr = $urandom; wdata = $urandom;
      end
    end while (!ack && lat < 20);
    chk("latency", 32'(lat), 32'(WaitCycles + 1));
    chk("rdata_at_ack", rdata, exp);
    got = rdata;
    req = 1'b0;
    @(negedge PCLK);
    chk("ack_low_in_hold", {31'd0, ack}, 32'd0);
    chk("rdata_in_hold", rdata, exp);
    @(negedge PCLK);
    if (c && !oor) m_mem[idx] = d;
    if (!c) m_rdata = exp;
  endtask

  typedef struct {
    logic        c;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[9];
  logic [31:0] got;
  logic [31:0] a;
  int          first, second, nacks;

  initial begin
    n_vec = 0; n_err = 0;
    m_rdata = 32'd0;
    req = 0; cmd = 0; addr = 0; wdata = 0;
    req0 = 0; cmd0 = 0; addr0 = 0; wdata0 = 0;

    tbl[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 32'h0000_0000};
    tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hA5A5_0001};
    tbl[2] = '{1'b1, 32'h0000_0020, 32'h1111_2222, 32'hA5A5_0001};
    tbl[3] = '{1'b1, 32'h0000_0014, 32'h1234_5678, 32'hA5A5_0001};
    tbl[4] = '{1'b0, 32'h0000_0020, 32'h0,         32'h1111_2222};
    tbl[5] = '{1'b0, 32'h0000_0014, 32'h0,         32'h1234_5678};
    tbl[6] = '{1'b0, 32'h8000_0010, 32'h0,         32'hA5A5_0001};
    tbl[7] = '{1'b1, 32'h0000_003C, 32'h0BAD_F00D, 32'hA5A5_0001};
    tbl[8] = '{1'b0, 32'h0000_003C, 32'h0,         32'h0BAD_F00D};

    // Reset values.
    PRESETN = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_ack0", {31'd0, ack0}, 32'd0);
    chk("reset_rdata0", rdata0, 32'd0);
    PRESETN = 1'b1;
    @(negedge PCLK);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      txn(tbl[i].c, tbl[i].a, tbl[i].d, got);
      chk($sformatf("table_%0d", i), got, tbl[i].exp);
    end

    // Abort: req dropped in the first WAIT cycle of a write.
    req = 1'b1; cmd = 1'b1; addr = 32'h20; wdata = 32'hFFFF_FFFF;
    @(negedge PCLK);
    req = 1'b0;
    nacks = 0;
    repeat (6) begin
      @(negedge PCLK);
      if (ack) nacks++;
    end
    chk("abort_no_ack", 32'(nacks), 32'd0);
    chk("abort_rdata_kept", rdata, 32'h0BAD_F00D);
    txn(1'b0, 32'h20, 32'h0, got);
    chk("abort_old_value", got, 32'h1111_2222);

    // Back-to-back reads with req held high.
    first = -1; second = -1; nacks = 0;
    req = 1'b1; cmd = 1'b0; addr = 32'h10;
    for (int n = 1; n <= 14; n++) begin
      @(negedge PCLK);
      if (first >= 0 && n == first + 1) chk("b2b_gap_low", {31'd0, ack}, 32'd0);
      if (first >= 0 && n == first + 1) chk("b2b_rdata_hold", rdata, 32'hA5A5_0001);
      if (ack) begin
        nacks++;
        if (first < 0) begin
          first = n;
          chk("b2b_rdata1", rdata, 32'hA5A5_0001);
          addr = 32'h14;
        end else if (second < 0) begin
          second = n;
          chk("b2b_rdata2", rdata, 32'h1234_5678);
          req = 1'b0;
        end
      end
    end
    req = 1'b0;
    m_rdata = 32'h1234_5678;
    chk("b2b_first_latency", 32'(first), 32'(WaitCycles + 1));
    chk("b2b_spacing", 32'(second - first), 32'(WaitCycles + 3));
    chk("b2b_ack_count", 32'(nacks), 32'd2);

    // Asynchronous reset in the middle of WAIT of a write.
    txn(1'b0, 32'h10, 32'h0, got);
    req = 1'b1; cmd = 1'b1; addr = 32'h14; wdata = 32'hDEAD_0000;
    @(negedge PCLK);
    #2 PRESETN = 1'b0;
    #1;
    chk("midwait_reset_ack", {31'd0, ack}, 32'd0);
    chk("midwait_reset_rdata", rdata, 32'd0);
    req = 1'b0;
    @(negedge PCLK);
    PRESETN = 1'b1;
    m_rdata = 32'd0;
    @(negedge PCLK);
    txn(1'b0, 32'h14, 32'h0, got);
    chk("reset_write_lost", got, 32'h1234_5678);

    // Zero wait states on the second instance.
    req0 = 1'b1; cmd0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h1234_5678;
    @(negedge PCLK);
    chk("zw_write_ack", {31'd0, ack0}, 32'd1);
    chk("zw_write_rdata", rdata0, 32'd0);
    req0 = 1'b0;
    @(negedge PCLK);
    chk("zw_write_hold", {31'd0, ack0}, 32'd0);
    @(negedge PCLK);
    req0 = 1'b1; cmd0 = 1'b0; addr0 = 32'h8;
    @(negedge PCLK);
    chk("zw_read_ack", {31'd0, ack0}, 32'd1);
    chk("zw_read_rdata", rdata0, 32'h1234_5678);
    req0 = 1'b0;
    @(negedge PCLK);
    chk("zw_read_hold_ack", {31'd0, ack0}, 32'd0);
    chk("zw_read_hold_rdata", rdata0, 32'h1234_5678);
    @(negedge PCLK);

    // Upper address bits: aliasing by default, out-of-range with the range check.
    txn(1'b1, 32'h0, 32'hCAFE_0000, got);
    txn(1'b1, 32'h400, 32'h0, got);
    txn(1'b0, 32'h0, 32'h0, got);
`ifdef XBAR_SLAVE_RAM_RANGE_CHECK_EN
    chk("range_word0_kept", got, 32'hCAFE_0000);
    txn(1'b0, 32'h400, 32'h0, got);
    chk("range_oor_read", got, 32'hDEAD_BEEF);
`else
    chk("alias_word0_written", got, 32'h0);
    txn(1'b0, 32'h400, 32'h0, got);
    chk("alias_read", got, 32'h0);
`endif

    // Randomized traffic against the model.
    wq.push_back(0); wq.push_back(4); wq.push_back(5); wq.push_back(8); wq.push_back(15);
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[30:10] = 21'd0;
      if ($urandom_range(0, 1) == 1) begin
        txn(1'b1, a, $urandom, got);
        if (!is_oor(a)) wq.push_back(int'(a[9:2]));
      end else begin
        a[9:2] = 8'(wq[$urandom_range(0, wq.size() - 1)]);
        txn(1'b0, a, 32'h0, got);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
